pixel_to_block_v1: RTL

Write-side counterpart of the BRAM pixel-block reader. Captures the 128x128 centre window (cols 96–223, rows 56–183) of the 320x240 QVGA camera stream on pclk. Packs two pixels per 32-bit word and writes 32-row stripes of 2048 words into a two-bank ping-pong BRAM. Hands each completed stripe to the DMA engine through a ready/ack handshake.

---
 rtl/pb_pkg.sv | 48 ++++
 rtl/pixel_to_block_v1_if.sv | 38 +++
 rtl/pixel_pair_packer.sv | 58 +++++
 rtl/pixel_to_block_v1.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// ============================================================================
// Module  : pb_pkg
// Purpose : Window/stripe constants, word layout and pixel field helper
//           for the pixel-to-block writer.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pb_pkg;

    localparam int COL_START   = 96;
    localparam int ROW_START   = 56;
    localparam int WIN_SIZE    = 128;
    localparam int STRIPE_ROWS = 32;
    localparam int BLOCK_WORDS = WIN_SIZE / 2 * STRIPE_ROWS;

    localparam int REF0 = 24;
    localparam int COL0 = 22;
    localparam int PIX0 = 16;
    localparam int REF1 = 8;
    localparam int COL1 = 6;
    localparam int PIX1 = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DROP    = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [1:0] colour;
        logic [5:0] pixel;
    } pix_fields_t;

    // Camera byte is {pixel[9:4], pad[3:2], colour[1:0]}; the pad bits are discarded.
    function automatic pix_fields_t pb_extract(input logic [9:0] pix);
        pix_fields_t f;
        logic [1:0]  unused_pad;
        unused_pad = pix[3:2];
        f.colour   = pix[1:0];
        f.pixel    = pix[9:4];
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_to_block_v1_if.sv
// ============================================================================
// Module  : pixel_to_block_v1_if
// Purpose : Camera input, BRAM write port and DMA handshake bundle.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pixel_to_block_v1_if;

    logic        pixel_valid;
    logic [9:0]  pixel_in;
    logic [7:0]  row_count;
    logic [8:0]  col_count;
    logic [31:0] bram_addr;
    logic [31:0] bram_wrdata;
    logic [3:0]  bram_we;
    logic        bram_en;
    logic        block_ready;
    logic        block_bank;
    logic        block_ack;
    logic        overrun;

    modport slave (
        input  pixel_valid, pixel_in, row_count, col_count, block_ack,
        output bram_addr, bram_wrdata, bram_we, bram_en,
        output block_ready, block_bank, overrun
    );

    modport master (
        output pixel_valid, pixel_in, row_count, col_count, block_ack,
        input  bram_addr, bram_wrdata, bram_we, bram_en,
        input  block_ready, block_bank, overrun
    );

endinterface

`default_nettype wire

// File: rtl/pixel_pair_packer.sv
// ============================================================================
// Module  : pixel_pair_packer
// Purpose : Latches the even-column pixel and packs it with the odd one.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pixel_pair_packer
    import pb_pkg::*;
(
    input  wire logic        pclk,
    input  wire logic        reset,
    input  wire logic        i_pix_valid,
    input  wire logic        i_odd,
    input  wire logic [9:0]  i_pixel,
    input  wire logic [7:0]  i_ref,
    output logic      [31:0] o_word,
    output logic             o_word_valid
);

    pix_fields_t r_pix0;
    logic        r_have0;
    pix_fields_t w_pix0;
    pix_fields_t w_pix1;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_pix0  <= '0;
            r_have0 <= 1'b0;
        end else if (i_pix_valid) begin
            if (!i_odd) begin
                r_pix0  <= pb_extract(i_pixel);
                r_have0 <= 1'b1;
            end else begin
                r_pix0  <= '0;
                r_have0 <= 1'b0;
            end
        end
    end

    // An odd pixel with no even partner still produces a word, with zeroed pixel0 fields.
    always_comb begin
        w_pix1       = pb_extract(i_pixel);
        w_pix0       = r_have0 ? r_pix0 : '0;
        o_word       = '0;
        o_word[REF0 +: 8] = i_ref;
        o_word[COL0 +: 2] = w_pix0.colour;
        o_word[PIX0 +: 6] = w_pix0.pixel;
        o_word[REF1 +: 8] = i_ref;
        o_word[COL1 +: 2] = w_pix1.colour;
        o_word[PIX1 +: 6] = w_pix1.pixel;
        o_word_valid = i_pix_valid && i_odd;
    end

endmodule

`default_nettype wire

// File: rtl/pixel_to_block_v1.sv
// ============================================================================
// Module  : pixel_to_block_v1
// Purpose : Captures the 128x128 centre window into ping-pong BRAM stripes
//           and hands completed stripes to DMA via ready/ack.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pixel_to_block_v1
    import pb_pkg::*;
(
    input  wire logic         pclk,
    input  wire logic         reset,
    pixel_to_block_v1_if.slave bus
);

    cap_state_t  r_state;
    cap_state_t  w_state_next;
    logic [5:0]  r_frame_cnt;
    logic        r_wbank;
    logic [1:0]  r_pending;
    logic [1:0]  r_fifo;
    logic [1:0]  r_count;
    logic        r_end_q;
    logic        r_overrun;
    logic        r_bram_en;
    logic [31:0] r_bram_addr;
    logic [31:0] r_bram_wrdata;

    logic        w_in_win;
    logic        w_stripe_start;
    logic        w_last_word;
    logic [6:0]  w_row_off;
    logic [5:0]  w_col_pair;
    logic [10:0] w_index;
    logic [7:0]  w_ref;
    logic [31:0] w_word;
    logic        w_word_valid;
    logic        w_wr;
    logic        w_done;
    logic        w_drop_start;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_fifo_next;
    logic [1:0]  w_count_next;
    logic [1:0]  w_pending_next;

    assign w_in_win = bus.pixel_valid
                   && (bus.col_count >= 9'(COL_START))
                   && (bus.col_count <= 9'(COL_START + WIN_SIZE - 1))
                   && (bus.row_count >= 8'(ROW_START))
                   && (bus.row_count <= 8'(ROW_START + WIN_SIZE - 1));

    assign w_row_off      = 7'(bus.row_count - 8'(ROW_START));
    assign w_col_pair     = 6'((bus.col_count - 9'(COL_START)) >> 1);
    assign w_index        = {w_row_off[4:0], w_col_pair};
    assign w_ref          = {r_frame_cnt, w_row_off[6:5]};
    assign w_stripe_start = w_in_win && (bus.col_count == 9'(COL_START))
                         && (w_row_off[4:0] == 5'd0);
    assign w_last_word    = w_in_win && (w_row_off[4:0] == 5'(STRIPE_ROWS - 1))
                         && (bus.col_count == 9'(COL_START + WIN_SIZE - 1));

    pixel_pair_packer u_packer (
        .pclk         (pclk),
        .reset        (reset),
        .i_pix_valid  (w_in_win),
        .i_odd        (bus.col_count[0]),
        .i_pixel      (bus.pixel_in),
        .i_ref        (w_ref),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Stripe-start decides capture vs drop from the pending flag of the current write bank.
    always_comb begin
        w_state_next = r_state;
        w_drop_start = 1'b0;
        w_wr         = 1'b0;
        w_done       = 1'b0;
        if (w_stripe_start) begin
            w_drop_start = r_pending[r_wbank];
            w_state_next = r_pending[r_wbank] ? ST_DROP : ST_CAPTURE;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    w_wr = w_word_valid;
                    if (w_last_word) begin
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (w_last_word) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_push = r_end_q && (r_count != 2'd2);
    assign w_pop  = bus.block_ack && (r_count != 2'd0);

    // Pop and push may coincide; the head advances and the new bank lands behind it.
    always_comb begin
        w_fifo_next    = r_fifo;
        w_count_next   = r_count;
        w_pending_next = r_pending;
        if (w_pop) begin
            w_pending_next[r_fifo[0]] = 1'b0;
        end
        if (w_push) begin
            w_pending_next[r_wbank] = 1'b1;
        end
        case ({w_push, w_pop})
            2'b01: begin
                w_fifo_next  = {1'b0, r_fifo[1]};
                w_count_next = r_count - 2'd1;
            end
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_fifo_next[0] = r_wbank;
                end else begin
                    w_fifo_next[1] = r_wbank;
                end
                w_count_next = r_count + 2'd1;
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    w_fifo_next[0] = r_wbank;
                end else begin
                    w_fifo_next = {r_wbank, r_fifo[1]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= 6'd0;
            r_wbank       <= 1'b0;
            r_pending     <= 2'b00;
            r_fifo        <= 2'b00;
            r_count       <= 2'd0;
            r_end_q       <= 1'b0;
            r_overrun     <= 1'b0;
            r_bram_en     <= 1'b0;
            r_bram_addr   <= 32'd0;
            r_bram_wrdata <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_end_q   <= w_done;
            r_overrun <= w_drop_start;
            r_bram_en <= w_wr;
            r_pending <= w_pending_next;
            r_fifo    <= w_fifo_next;
            r_count   <= w_count_next;
            if (bus.pixel_valid && (bus.row_count == 8'd0) && (bus.col_count == 9'd0)) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
            if (w_wr) begin
                r_bram_addr   <= {20'd0, r_wbank, w_index};
                r_bram_wrdata <= w_word;
            end
            if (r_end_q) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    assign bus.bram_en     = r_bram_en;
    assign bus.bram_we     = {4{r_bram_en}};
    assign bus.bram_addr   = r_bram_addr;
    assign bus.bram_wrdata = r_bram_wrdata;
    assign bus.block_ready = (r_count != 2'd0);
    assign bus.block_bank  = r_fifo[0];
    assign bus.overrun     = r_overrun;

endmodule

`default_nettype wire
